// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch unit.
//   XLEN_DEFAULT     : default address/instruction width
//   RESET_PC_DEFAULT : default first fetch address
//   PC_INCR          : byte distance between sequential instruction words
//   state_e          : fetch control state (RUN fetches, DRAIN discards)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INCR          = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, inst} pairs for the fetch unit.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   flush_i      : empty the FIFO; overrides push and pop in the same cycle
//   push_i       : write data_i (ignored when full)
//   data_i       : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   data_o       : head entry (content undefined when empty_o is high)
//   empty_o      : no entries held
//   count_o      : number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_push  = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
        do_pop   = pop_i && !flush_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; empty_o guards every read, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch: issues pipelined word requests to instruction memory,
// buffers in-order responses with their PCs and hands them to decode.
// Outstanding requests plus buffered entries never exceed DEPTH, so every
// response always has a FIFO slot. A redirect flushes the buffer and, if
// responses are still in flight, enters DRAIN to discard them.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   mem_req_o/_addr_o   : memory request and word-aligned address
//   mem_gnt_i           : request accepted
//   mem_rvalid_i/_rdata_i: in-order response
//   redirect_i/_pc_i    : branch/jump redirect strobe and target
//   inst_valid_o/_ready_i, inst_o, pc_o : decode handshake and head entry
//   perf_fetched_o      : delivered-instruction count
// Build option: FETCH_UNIT_PERF_EN enables the perf_fetched_o counter;
// without it the port reads 0.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     perf_fetched_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;   // PC of the next response to arrive
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_head;
    logic              gnt_acc, push, pop;
    logic [XLEN-1:0]   redirect_target;

    assign redirect_target = redirect_pc_i & ~XLEN'(3);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        mem_req_o     = 1'b0;
        // rst_i gates the request so it is low throughout reset and rises
        // in the first cycle after release.
        if (!rst_i && !redirect_i && (state_q == RUN) &&
            ((fifo_count + outstanding_q) < CNT_W'(DEPTH))) begin
            mem_req_o = 1'b1;
        end
        gnt_acc       = mem_req_o && mem_gnt_i;
        // Responses during DRAIN or in a redirect cycle belong to the old path.
        push          = mem_rvalid_i && (state_q == RUN) && !redirect_i;
        outstanding_d = outstanding_q + CNT_W'(gnt_acc) - CNT_W'(mem_rvalid_i);

        if (gnt_acc) fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
        if (push)    resp_pc_d  = resp_pc_q + XLEN'(PC_INCR);

        if (redirect_i) begin
            // No grants are taken while draining, so once the old responses
            // are gone the next response is for the redirect target.
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            state_d    = (outstanding_d != '0) ? DRAIN : RUN;
        end else if ((state_q == DRAIN) && (outstanding_d == '0)) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  ({resp_pc_q, mem_rdata_i}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem_addr_o   = fetch_pc_q;
    assign inst_valid_o = !fifo_empty;
    assign pop          = inst_valid_o && inst_ready_i;
    assign {pc_o, inst_o} = inst_valid_o ? fifo_head : '0;

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (pop) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_fetched_o = perf_q;
`else
    assign perf_fetched_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0). A single
// process drives each cycle: it plays the memory (grant enable, fixed
// response latency, in-order responses whose data is addr + 0x1000_0000),
// logs granted addresses and delivered {pc, inst} pairs, and compares them
// with hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] perf_fetched_o;

    fetch_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .perf_fetched_o (perf_fetched_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    int unsigned cyc;
    int unsigned lat = 1;
    bit          gnt_en = 1'b0;
    int          first_valid = -1;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr + 32'h1000_0000;
    endfunction

    function automatic logic [31:0] perf_exp(input int unsigned pops);
`ifdef FETCH_UNIT_PERF_EN
        return pops;
`else
        return 32'd0;
`endif
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        resp_t r;
        mem_gnt_i    = gnt_en;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (!rst_i && rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = inst_of(rq[0].addr);
            void'(rq.pop_front());
        end
        #1;
        if (mem_req_o && mem_gnt_i) begin
            gnt_log.push_back(mem_addr_o);
            r.addr = mem_addr_o;
            r.due  = cyc + lat;
            rq.push_back(r);
        end
        if (inst_valid_o && inst_ready_i) begin
            pop_pc.push_back(pc_o);
            pop_inst.push_back(inst_o);
        end
        if (inst_valid_o && first_valid < 0) first_valid = int'(cyc);
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic run(input int unsigned n);
        for (int i = 0; i < int'(n); i++) cycle();
    endtask

    // Memory shares rst_i, so its pending responses vanish with the reset.
    task automatic do_reset();
        rst_i        = 1'b1;
        redirect_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        rq.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        gnt_log.delete();
        pop_pc.delete();
        pop_inst.delete();
        cyc         = 0;
        first_valid = -1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned g;

        // Reset values while rst_i is held.
        repeat (2) @(negedge clk_i);
        check("rst_req",   {31'd0, mem_req_o},    32'd0);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst",  inst_o,                32'd0);
        check("rst_pc",    pc_o,                  32'd0);
        check("rst_perf",  perf_fetched_o,        32'd0);

        // Streaming: grant always, latency 1, decode always ready.
        gnt_en = 1'b1; lat = 1; inst_ready_i = 1'b1;
        do_reset();
        check("rel_req",  {31'd0, mem_req_o}, 32'd1);
        check("rel_addr", mem_addr_o,         32'd0);
        run(10);
        check("s_first_valid", first_valid, 32'd2);
        check("s_gnt0", gnt_log[0], 32'h0);
        check("s_gnt1", gnt_log[1], 32'h4);
        check("s_gnt2", gnt_log[2], 32'h8);
        check("s_pc0",  pop_pc[0],  32'h0);
        check("s_pc1",  pop_pc[1],  32'h4);
        check("s_pc2",  pop_pc[2],  32'h8);
        check("s_inst2", pop_inst[2], 32'h1000_0008);
        check("s_perf", perf_fetched_o, perf_exp(pop_pc.size()));

        // Decode stalled: four grants fill the buffer, then requests stop.
        inst_ready_i = 1'b0;
        do_reset();
        run(10);
        check("stall_ngnt",  gnt_log.size(),          32'd4);
        check("stall_req",   {31'd0, mem_req_o},      32'd0);
        check("stall_valid", {31'd0, inst_valid_o},   32'd1);
        check("stall_pc",    pc_o,                    32'h0);
        check("stall_inst",  inst_o,                  32'h1000_0000);
        check("stall_npop",  pop_pc.size(),           32'd0);
        inst_ready_i = 1'b1;
        run(6);
        check("resume_gnt4", gnt_log[4], 32'h10);
        check("resume_pc3",  pop_pc[3],  32'hC);
        check("resume_perf", perf_fetched_o, perf_exp(pop_pc.size()));

        // Redirect to 0x103 with two requests in flight (latency 3).
        lat = 3;
        do_reset();
        run(2);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        #1;
        check("rd_req_now", {31'd0, mem_req_o}, 32'd0);
        cycle();
        redirect_i = 1'b0;
        #1;
        check("drain_req0",   {31'd0, mem_req_o},    32'd0);
        cycle();
        check("drain_req1",   {31'd0, mem_req_o},    32'd0);
        check("drain_valid",  {31'd0, inst_valid_o}, 32'd0);
        cycle();
        check("drain_done_req",  {31'd0, mem_req_o}, 32'd1);
        check("drain_done_addr", mem_addr_o,         32'h100);
        run(8);
        check("rd_gnt2",  gnt_log[2],  32'h100);
        check("rd_pc0",   pop_pc[0],   32'h100);
        check("rd_inst0", pop_inst[0], 32'h1000_0100);

        // Redirect while a request waits for grant.
        lat = 1; gnt_en = 1'b0;
        do_reset();
        run(2);
        check("hold_req",  {31'd0, mem_req_o}, 32'd1);
        check("hold_addr", mem_addr_o,         32'h0);
        gnt_en = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        #1;
        check("wd_req_now", {31'd0, mem_req_o}, 32'd0);
        cycle();
        redirect_i = 1'b0;
        run(6);
        check("wd_gnt0",  gnt_log[0],  32'h200);
        check("wd_pc0",   pop_pc[0],   32'h200);
        check("wd_inst0", pop_inst[0], 32'h1000_0200);

        // Address wrap from 0xFFFF_FFFC; unaligned target bits are dropped.
        do_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        cycle();
        redirect_i = 1'b0;
        run(6);
        check("wrap_gnt0", gnt_log[0], 32'hFFFF_FFFC);
        check("wrap_gnt1", gnt_log[1], 32'h0);
        check("wrap_gnt2", gnt_log[2], 32'h4);
        check("wrap_pc1",  pop_pc[1],  32'h0);

        // Reset with three requests outstanding.
        do_reset();
        run(6);
        gnt_en = 1'b0;
        run(4);
        check("pre_perf", perf_fetched_o, perf_exp(pop_pc.size()));
        g = gnt_log.size();
        lat = 3; gnt_en = 1'b1;
        run(3);
        check("pre_ngnt", gnt_log.size() - g, 32'd3);
        rst_i = 1'b1;
        rq.delete();
        #1;
        check("mid_rst_req",   {31'd0, mem_req_o},    32'd0);
        check("mid_rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("mid_rst_inst",  inst_o,                32'd0);
        check("mid_rst_pc",    pc_o,                  32'd0);
        check("mid_rst_perf",  perf_fetched_o,        32'd0);
        lat = 1;
        do_reset();
        check("post_rst_req",  {31'd0, mem_req_o}, 32'd1);
        check("post_rst_addr", mem_addr_o,         32'h0);
        run(6);
        check("post_rst_pc0",  pop_pc[0],  32'h0);
        check("post_rst_perf", perf_fetched_o, perf_exp(pop_pc.size()));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
